// File: rtl/al_spi_pkg.sv
// Shared constants for the SPI memory buffer.
//   DATA_W       : RAM word width
//   ADDR_W_DEF   : default word-address width
//   PRIO_*       : HOST_PRIO encodings (which side wins RAM-port conflicts)
//   side_e       : identifies the requester owning the RAM read port
package al_spi_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W_DEF  = 6;
  localparam int unsigned PRIO_ENGINE = 0;
  localparam int unsigned PRIO_HOST   = 1;

  typedef enum logic {
    SIDE_ENGINE = 1'b0,
    SIDE_HOST   = 1'b1
  } side_e;

endpackage

// File: rtl/al_ram_sdp.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Read-first: a read and write to the same address in one cycle returns
// the old word. Contents are not reset.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request, data on rdata one cycle later
//   rdata        : registered read data
module al_ram_sdp
  import al_spi_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports in one block; the read samples mem before this edge's write lands.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/al_spi_membuf.sv
// Shared word buffer between the SPI memory engine and a host.
// Arbitrates a single RAM write port and single RAM read port between the
// two sides, runs a 2-cycle read pipeline per side (one read in flight per
// side), and counts engine write beats.
//   clk, rst_n            : clock, async active-low reset
//   e_w*  / h_w*          : engine / host write channels
//   e_ar* / h_ar*         : engine / host read-address channels
//   e_r*  / h_r*          : engine / host read-data channels
//   clr_cnt               : clears e_wcnt (a same-cycle engine write counts as 1)
//   e_wcnt                : saturating engine write-beat count
module al_spi_membuf
  import al_spi_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned HOST_PRIO = PRIO_ENGINE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] e_wdata,
  input  logic [ADDR_W-1:0] e_waddr,
  input  logic              e_wvalid,
  output logic              e_wready,
  input  logic [ADDR_W-1:0] e_araddr,
  input  logic              e_arvalid,
  output logic              e_arready,
  output logic [DATA_W-1:0] e_rdata,
  output logic              e_rvalid,
  input  logic              e_rready,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic [ADDR_W-1:0] h_waddr,
  input  logic              h_wvalid,
  output logic              h_wready,
  input  logic [ADDR_W-1:0] h_araddr,
  input  logic              h_arvalid,
  output logic              h_arready,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_rvalid,
  input  logic              h_rready,
  input  logic              clr_cnt,
  output logic [ADDR_W:0]   e_wcnt
);

  localparam int unsigned     CNT_W     = ADDR_W + 1;
  localparam int unsigned     DEPTH     = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam bit              HOST_WINS = (HOST_PRIO == PRIO_HOST);

  logic              rdy_en;
  logic              e_pend;
  logic              h_pend;

  logic              e_avail_c;
  logic              h_avail_c;
  logic              e_w_grant_c;
  logic              h_w_grant_c;
  logic              e_ar_grant_c;
  logic              h_ar_grant_c;
  logic              e_w_hs_c;
  logic              h_w_hs_c;
  logic              e_ar_hs_c;
  logic              h_ar_hs_c;

  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_waddr_c;
  logic [DATA_W-1:0] ram_wdata_c;
  logic              ram_re_c;
  side_e             rd_side_c;
  logic [ADDR_W-1:0] ram_raddr_c;
  logic [DATA_W-1:0] ram_rdata;

  // Readies stay low through reset and for the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  // Arbitration: a side's ready never looks at its own valid, only the rival's.
  always_comb begin
    e_avail_c    = !e_pend && (!e_rvalid || e_rready);
    h_avail_c    = !h_pend && (!h_rvalid || h_rready);
    e_w_grant_c  = 1'b1;
    h_w_grant_c  = 1'b1;
    e_ar_grant_c = 1'b1;
    h_ar_grant_c = 1'b1;
    if (HOST_WINS) begin
      e_w_grant_c  = !h_wvalid;
      e_ar_grant_c = !(h_arvalid && h_avail_c);
    end else begin
      h_w_grant_c  = !e_wvalid;
      h_ar_grant_c = !(e_arvalid && e_avail_c);
    end
    e_wready  = rdy_en && e_w_grant_c;
    h_wready  = rdy_en && h_w_grant_c;
    e_arready = rdy_en && e_avail_c && e_ar_grant_c;
    h_arready = rdy_en && h_avail_c && h_ar_grant_c;
  end

  assign e_w_hs_c  = e_wvalid  && e_wready;
  assign h_w_hs_c  = h_wvalid  && h_wready;
  assign e_ar_hs_c = e_arvalid && e_arready;
  assign h_ar_hs_c = h_arvalid && h_arready;

  // RAM port steering; grants make each port's handshakes mutually exclusive.
  always_comb begin
    ram_we_c    = e_w_hs_c || h_w_hs_c;
    ram_waddr_c = e_w_hs_c ? e_waddr : h_waddr;
    ram_wdata_c = e_w_hs_c ? e_wdata : h_wdata;
    ram_re_c    = e_ar_hs_c || h_ar_hs_c;
    rd_side_c   = e_ar_hs_c ? SIDE_ENGINE : SIDE_HOST;
    ram_raddr_c = (rd_side_c == SIDE_ENGINE) ? e_araddr : h_araddr;
  end

  al_ram_sdp #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .waddr (ram_waddr_c),
    .wdata (ram_wdata_c),
    .re    (ram_re_c),
    .raddr (ram_raddr_c),
    .rdata (ram_rdata)
  );

  // Engine read pipeline: pend marks the RAM output cycle for this side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_pend   <= 1'b0;
      e_rvalid <= 1'b0;
      e_rdata  <= '0;
    end else begin
      e_pend <= e_ar_hs_c;
      if (e_pend) begin
        e_rvalid <= 1'b1;
        e_rdata  <= ram_rdata;
      end else if (e_rready) begin
        e_rvalid <= 1'b0;
      end
    end
  end

  // Host read pipeline, same shape as the engine's.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_pend   <= 1'b0;
      h_rvalid <= 1'b0;
      h_rdata  <= '0;
    end else begin
      h_pend <= h_ar_hs_c;
      if (h_pend) begin
        h_rvalid <= 1'b1;
        h_rdata  <= ram_rdata;
      end else if (h_rready) begin
        h_rvalid <= 1'b0;
      end
    end
  end

  // Engine write-beat counter; a clear coinciding with a beat leaves 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_wcnt <= '0;
    end else if (clr_cnt) begin
      e_wcnt <= e_w_hs_c ? CNT_W'(1) : '0;
    end else if (e_w_hs_c && (e_wcnt != CNT_MAX)) begin
      e_wcnt <= e_wcnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_al_spi_membuf.sv
// Directed self-checking bench for al_spi_membuf (ADDR_W=6, HOST_PRIO=0).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_al_spi_membuf;

  localparam int unsigned AW = 6;

  logic          clk;
  logic          rst_n;
  logic [31:0]   e_wdata, h_wdata;
  logic [AW-1:0] e_waddr, h_waddr, e_araddr, h_araddr;
  logic          e_wvalid, e_wready, e_arvalid, e_arready, e_rvalid, e_rready;
  logic          h_wvalid, h_wready, h_arvalid, h_arready, h_rvalid, h_rready;
  logic [31:0]   e_rdata, h_rdata;
  logic          clr_cnt;
  logic [AW:0]   e_wcnt;

  int errors = 0;
  int checks = 0;

  al_spi_membuf #(.ADDR_W(AW), .HOST_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .e_wdata(e_wdata), .e_waddr(e_waddr), .e_wvalid(e_wvalid), .e_wready(e_wready),
    .e_araddr(e_araddr), .e_arvalid(e_arvalid), .e_arready(e_arready),
    .e_rdata(e_rdata), .e_rvalid(e_rvalid), .e_rready(e_rready),
    .h_wdata(h_wdata), .h_waddr(h_waddr), .h_wvalid(h_wvalid), .h_wready(h_wready),
    .h_araddr(h_araddr), .h_arvalid(h_arvalid), .h_arready(h_arready),
    .h_rdata(h_rdata), .h_rvalid(h_rvalid), .h_rready(h_rready),
    .clr_cnt(clr_cnt), .e_wcnt(e_wcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic host_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk); h_waddr = a; h_wdata = d; h_wvalid = 1'b1;
    @(negedge clk); h_wvalid = 1'b0;
  endtask

  // Issues one read; lat counts falling edges after the address handshake until rvalid.
  task automatic do_read(input bit host, input logic [AW-1:0] a,
                         output logic [31:0] d, output int lat);
    int n;
    @(negedge clk);
    if (host) begin h_araddr = a; h_arvalid = 1'b1; h_rready = 1'b1; end
    else      begin e_araddr = a; e_arvalid = 1'b1; e_rready = 1'b1; end
    #1; n = 0;
    while (!(host ? h_arready : e_arready) && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    h_arvalid = host ? 1'b0 : h_arvalid;
    e_arvalid = host ? e_arvalid : 1'b0;
    #1; lat = 1;
    while (!(host ? h_rvalid : e_rvalid) && lat < 20) begin @(negedge clk); #1; lat++; end
    d = host ? h_rdata : e_rdata;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    e_wvalid = 1'b1; e_arvalid = 1'b1; h_wvalid = 1'b1; h_arvalid = 1'b1;
    e_waddr = '0; h_waddr = '0; e_araddr = '0; h_araddr = '0;
    e_wdata = '0; h_wdata = '0; e_rready = 1'b1; h_rready = 1'b1; clr_cnt = 1'b0;
    @(negedge clk); #1;
    checks++; if (e_rvalid !== 1'b0) begin errors++; $display("FAIL rst_e_rvalid got %b want 0", e_rvalid); end
    checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL rst_h_rvalid got %b want 0", h_rvalid); end
    checks++; if (e_wcnt !== '0) begin errors++; $display("FAIL rst_wcnt got %0d want 0", e_wcnt); end
    checks++; if (e_rdata !== 32'h0 || h_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h want 0/0", e_rdata, h_rdata); end
    checks++; if ({e_wready, h_wready, e_arready, h_arready} !== 4'b0) begin errors++; $display("FAIL rst_readies got %b want 0000", {e_wready, h_wready, e_arready, h_arready}); end
    @(negedge clk);
    e_wvalid = 1'b0; e_arvalid = 1'b0; h_wvalid = 1'b0; h_arvalid = 1'b0; rst_n = 1'b1;
    #1;
    checks++; if (e_arready !== 1'b0) begin errors++; $display("FAIL rel_arready_early got %b want 0", e_arready); end
    @(negedge clk); #1;
    checks++; if ({e_arready, e_wready, h_wready} !== 3'b111) begin errors++; $display("FAIL rel_readies got %b want 111", {e_arready, e_wready, h_wready}); end
  endtask

  task automatic test_write_read;
    logic [31:0] d; int lat;
    host_write(6'd5, 32'hDEAD_BEEF);
    do_read(1'b0, 6'd5, d, lat);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_data got %h want deadbeef", d); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_rd_latency got %0d want 2", lat); end
    @(negedge clk); #1;
    checks++; if (e_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_clear got %b want 0", e_rvalid); end
    do_read(1'b1, 6'd5, d, lat);
    checks++; if (d !== 32'hDEAD_BEEF || lat !== 2) begin errors++; $display("FAIL host_rd got %h lat %0d want deadbeef lat 2", d, lat); end
  endtask

  task automatic test_conflict;
    logic [31:0] d; int lat;
    @(negedge clk);
    e_waddr = 6'd3; e_wdata = 32'h1111_1111; e_wvalid = 1'b1;
    h_waddr = 6'd3; h_wdata = 32'h2222_2222; h_wvalid = 1'b1;
    #1;
    checks++; if ({e_wready, h_wready} !== 2'b10) begin errors++; $display("FAIL wr_arb got %b want 10", {e_wready, h_wready}); end
    @(negedge clk); e_wvalid = 1'b0; #1;
    checks++; if (h_wready !== 1'b1) begin errors++; $display("FAIL wr_arb_host_next got %b want 1", h_wready); end
    @(negedge clk); h_wvalid = 1'b0;
    host_write(6'd11, 32'hB0B0_000B);
    // Simultaneous reads: engine first, host on the following cycle.
    @(negedge clk);
    e_araddr = 6'd3; e_arvalid = 1'b1; h_araddr = 6'd11; h_arvalid = 1'b1; #1;
    checks++; if ({e_arready, h_arready} !== 2'b10) begin errors++; $display("FAIL rd_arb got %b want 10", {e_arready, h_arready}); end
    @(negedge clk); e_arvalid = 1'b0; #1;
    checks++; if (h_arready !== 1'b1) begin errors++; $display("FAIL rd_interleave got %b want 1", h_arready); end
    @(negedge clk); h_arvalid = 1'b0; #1;
    checks++; if (e_rvalid !== 1'b1 || e_rdata !== 32'h2222_2222) begin errors++; $display("FAIL conflict_final got %b/%h want 1/22222222", e_rvalid, e_rdata); end
    @(negedge clk); #1;
    checks++; if (h_rvalid !== 1'b1 || h_rdata !== 32'hB0B0_000B || e_rvalid !== 1'b0) begin errors++; $display("FAIL interleave_host got %b/%h e_rvalid %b want 1/b0b0000b 0", h_rvalid, h_rdata, e_rvalid); end
    do_read(1'b1, 6'd3, d, lat);
    checks++; if (d !== 32'h2222_2222) begin errors++; $display("FAIL conflict_host_rd got %h want 22222222", d); end
  endtask

  task automatic test_backpressure;
    host_write(6'd7, 32'h7777_0007);
    @(negedge clk); e_araddr = 6'd7; e_arvalid = 1'b1; e_rready = 1'b0; #1;
    checks++; if (e_arready !== 1'b1) begin errors++; $display("FAIL bp_accept got %b want 1", e_arready); end
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 2) begin h_waddr = 6'd7; h_wdata = 32'hBBBB_0007; h_wvalid = 1'b1; end
      if (i == 3) h_wvalid = 1'b0;
      #1;
      checks++; if (e_arready !== 1'b0) begin errors++; $display("FAIL bp_arready[%0d] got %b want 0", i, e_arready); end
      if (i > 0) begin
        checks++; if (e_rvalid !== 1'b1 || e_rdata !== 32'h7777_0007) begin errors++; $display("FAIL bp_hold[%0d] got %b/%h want 1/77770007", i, e_rvalid, e_rdata); end
      end
    end
    @(negedge clk); e_rready = 1'b1; #1;
    checks++; if (e_arready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", e_arready); end
    @(negedge clk); e_arvalid = 1'b0; #1;
    checks++; if (e_rvalid !== 1'b0) begin errors++; $display("FAIL bp_clear got %b want 0", e_rvalid); end
    @(negedge clk); #1;
    checks++; if (e_rvalid !== 1'b1 || e_rdata !== 32'hBBBB_0007) begin errors++; $display("FAIL bp_new got %b/%h want 1/bbbb0007", e_rvalid, e_rdata); end
  endtask

  task automatic test_counter;
    logic [31:0] d; int lat;
    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0; #1;
    checks++; if (e_wcnt !== 7'd0) begin errors++; $display("FAIL cnt_clear got %0d want 0", e_wcnt); end
    for (int i = 0; i < 70; i++) begin
      @(negedge clk); #1;
      if (i == 10) begin
        checks++; if (e_wcnt !== 7'd10) begin errors++; $display("FAIL cnt_10 got %0d want 10", e_wcnt); end
      end
      if (i == 64) begin
        checks++; if (e_wcnt !== 7'd64) begin errors++; $display("FAIL cnt_64 got %0d want 64", e_wcnt); end
      end
      e_waddr = AW'(i); e_wdata = 32'(i); e_wvalid = 1'b1;
    end
    @(negedge clk); e_wvalid = 1'b0; #1;
    checks++; if (e_wcnt !== 7'd64) begin errors++; $display("FAIL cnt_sat got %0d want 64", e_wcnt); end
    @(negedge clk); clr_cnt = 1'b1; e_waddr = 6'd20; e_wdata = 32'h1414_1414; e_wvalid = 1'b1;
    @(negedge clk); clr_cnt = 1'b0; e_wvalid = 1'b0; #1;
    checks++; if (e_wcnt !== 7'd1) begin errors++; $display("FAIL cnt_clr_hs got %0d want 1", e_wcnt); end
    do_read(1'b0, 6'd5, d, lat);
    checks++; if (d !== 32'd69) begin errors++; $display("FAIL wrap_addr5 got %h want 45", d); end
    do_read(1'b1, 6'd10, d, lat);
    checks++; if (d !== 32'd10) begin errors++; $display("FAIL addr10 got %h want a", d); end
    do_read(1'b0, 6'd20, d, lat);
    checks++; if (d !== 32'h1414_1414) begin errors++; $display("FAIL addr20 got %h want 14141414", d); end
  endtask

  task automatic test_read_first;
    logic [31:0] d; int lat;
    host_write(6'd9, 32'h0);
    @(negedge clk);
    e_waddr = 6'd9; e_wdata = 32'hA5A5_A5A5; e_wvalid = 1'b1;
    h_araddr = 6'd9; h_arvalid = 1'b1; h_rready = 1'b1; #1;
    checks++; if (h_arready !== 1'b1 || e_wready !== 1'b1) begin errors++; $display("FAIL rf_ready got %b%b want 11", h_arready, e_wready); end
    @(negedge clk); e_wvalid = 1'b0; h_arvalid = 1'b0;
    @(negedge clk); #1;
    checks++; if (h_rvalid !== 1'b1 || h_rdata !== 32'h0) begin errors++; $display("FAIL rf_old got %b/%h want 1/0", h_rvalid, h_rdata); end
    do_read(1'b1, 6'd9, d, lat);
    checks++; if (d !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rf_new got %h want a5a5a5a5", d); end
  endtask

  task automatic test_reset_midread;
    @(negedge clk); h_araddr = 6'd5; h_arvalid = 1'b1; h_rready = 1'b1;
    @(negedge clk); h_arvalid = 1'b0; rst_n = 1'b0; #1;
    checks++; if (h_rvalid !== 1'b0 || h_arready !== 1'b0 || e_wcnt !== 7'd0) begin errors++; $display("FAIL mid_rst got rvalid %b arready %b cnt %0d want 0 0 0", h_rvalid, h_arready, e_wcnt); end
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (h_arready !== 1'b0) begin errors++; $display("FAIL mid_rel_early got %b want 0", h_arready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL mid_no_rvalid[%0d] got %b want 0", i, h_rvalid); end
      if (i == 0) begin
        checks++; if (h_arready !== 1'b1) begin errors++; $display("FAIL mid_arready got %b want 1", h_arready); end
      end
    end
    checks++; if (e_wcnt !== 7'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", e_wcnt); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_backpressure();
    test_counter();
    test_read_first();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
